conv: RTL and testbench

- Two-layer, per-channel 3x3 valid convolution engine for the NPU front end.
- For each of CHAN channels it computes:
  - conv1: 3x3 unsigned-image x signed-weight convolution, then ReLU.
  - conv2: 3x3 depthwise convolution of that channel's conv1 map, then ReLU.
- Sums the CHAN conv2 maps into one 2-D output buffer and flags completion with out_valid.
- Started by a trigger pulse from the controller; the result feeds the downstream dense stage.

---
 rtl/conv.sv | 182 ++++++++++++++++++
 tb/tb_conv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv.sv
// Two-layer per-channel 3x3 valid convolution (conv1 + ReLU, depthwise conv2 + ReLU),
// channel-summed into out_buff; one pixel per cycle through a 9-multiplier stage.
`default_nettype none

module conv #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN1_H  = 16,
  parameter int IN1_W  = 15,
  parameter int OUT1_H = 14,
  parameter int OUT1_W = 13,
  parameter int OUT2_H = 12,
  parameter int OUT2_W = 11,
  parameter int CHAN   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic        [7:0]  in_img   [0:IN1_H-1][0:IN1_W-1],
  input  logic signed [7:0]  w_conv1  [0:K_H-1][0:K_W-1][0:CHAN-1],
  input  logic signed [7:0]  w_conv2  [0:K_H-1][0:K_W-1][0:CHAN-1],
  output logic signed [23:0] out_buff [0:OUT2_H-1][0:OUT2_W-1],
  output logic               out_valid
);

  localparam int NT  = K_H * K_W;
  localparam int RW  = $clog2(OUT1_H);
  localparam int CW  = $clog2(OUT1_W);
  localparam int IRW = $clog2(IN1_H);
  localparam int ICW = $clog2(IN1_W);
  localparam int HW  = (CHAN > 1) ? $clog2(CHAN) : 1;

  localparam logic [RW-1:0] R1_LAST = RW'(OUT1_H - 1);
  localparam logic [CW-1:0] C1_LAST = CW'(OUT1_W - 1);
  localparam logic [RW-1:0] R2_LAST = RW'(OUT2_H - 1);
  localparam logic [CW-1:0] C2_LAST = CW'(OUT2_W - 1);
  localparam logic [HW-1:0] CH_LAST = HW'(CHAN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV1 = 2'd1,
    CONV2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [HW-1:0]   ch;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic [23:0]     c1buf [0:OUT1_H-1][0:OUT1_W-1];

  // Product stage: registered products plus the destination of their sum.
  logic            pv;
  logic            pk;
  logic            plast;
  logic [RW-1:0]   pr;
  logic [CW-1:0]   pc;
  logic [23:0]     prod   [0:NT-1];
  logic [31:0]     prod_c [0:NT-1];
  logic [23:0]     sum;
  logic [23:0]     relu;

  always_comb begin
    logic [IRW-1:0] ir;
    logic [ICW-1:0] ic;
    logic [RW-1:0]  br;
    logic [CW-1:0]  bc;
    ir = '0;
    ic = '0;
    br = '0;
    bc = '0;
    for (int k = 0; k < NT; k++) prod_c[k] = '0;
    for (int i = 0; i < K_H; i++) begin
      for (int j = 0; j < K_W; j++) begin
        if (state == CONV1) begin
          ir = IRW'(r) + IRW'(i);
          ic = ICW'(c) + ICW'(j);
          prod_c[i*K_W+j] = $signed({24'd0, in_img[ir][ic]})
                          * $signed({{24{w_conv1[i][j][ch][7]}}, w_conv1[i][j][ch]});
        end else if (state == CONV2) begin
          br = r + RW'(i);
          bc = c + CW'(j);
          prod_c[i*K_W+j] = $signed({{8{c1buf[br][bc][23]}}, c1buf[br][bc]})
                          * $signed({{24{w_conv2[i][j][ch][7]}}, w_conv2[i][j][ch]});
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NT; k++) sum = sum + prod[k];
    relu = sum[23] ? 24'd0 : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      r         <= '0;
      c         <= '0;
      pv        <= 1'b0;
      pk        <= 1'b0;
      plast     <= 1'b0;
      pr        <= '0;
      pc        <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < NT; k++) prod[k] <= '0;
      for (int y = 0; y < OUT1_H; y++)
        for (int x = 0; x < OUT1_W; x++) c1buf[y][x] <= '0;
      for (int y = 0; y < OUT2_H; y++)
        for (int x = 0; x < OUT2_W; x++) out_buff[y][x] <= '0;
    end else begin
      pv    <= 1'b0;
      plast <= 1'b0;
      if (pv) begin
        if (!pk) c1buf[pr][pc] <= relu;
        else     out_buff[pr][pc] <= out_buff[pr][pc] + relu;
        if (plast) out_valid <= 1'b1;
      end
      case (state)
        CONV1: begin
          pv <= 1'b1;
          pk <= 1'b0;
          pr <= r;
          pc <= c;
          for (int k = 0; k < NT; k++) prod[k] <= prod_c[k][23:0];
          if (c == C1_LAST) begin
            c <= '0;
            if (r == R1_LAST) begin
              r     <= '0;
              state <= CONV2;
            end else begin
              r <= r + RW'(1);
            end
          end else begin
            c <= c + CW'(1);
          end
        end
        CONV2: begin
          pv <= 1'b1;
          pk <= 1'b1;
          pr <= r;
          pc <= c;
          for (int k = 0; k < NT; k++) prod[k] <= prod_c[k][23:0];
          if (c == C2_LAST) begin
            c <= '0;
            if (r == R2_LAST) begin
              r <= '0;
              if (ch == CH_LAST) begin
                state <= DONE;
                plast <= 1'b1;
              end else begin
                ch    <= ch + HW'(1);
                state <= CONV1;
              end
            end else begin
              r <= r + RW'(1);
            end
          end else begin
            c <= c + CW'(1);
          end
        end
        default: begin
          // DONE only accepts a restart once the final accumulate has landed.
          if (trigger && (state == IDLE || out_valid)) begin
            state     <= CONV1;
            ch        <= '0;
            r         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            for (int y = 0; y < OUT2_H; y++)
              for (int x = 0; x < OUT2_W; x++) out_buff[y][x] <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv.sv
// Randomized self-checking bench for conv against a plain-arithmetic reference model.
`default_nettype none

module tb_conv;
  localparam int LAT = 3141;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic        [7:0]  img [0:15][0:14];
  logic signed [7:0]  w1  [0:2][0:2][0:9];
  logic signed [7:0]  w2  [0:2][0:2][0:9];
  logic signed [23:0] ob  [0:11][0:10];
  logic               ov;

  logic signed [23:0] exp_buf [0:11][0:10];
  longint c1m [0:13][0:12];
  int  checks = 0;
  int  passes = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  conv dut (
    .clk(clk), .rst(rst), .trigger(trigger), .in_img(img),
    .w_conv1(w1), .w_conv2(w2), .out_buff(ob), .out_valid(ov)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: straight definition of both layers, sums in 64-bit, wrap to 24 bits.
  function automatic void compute_model();
    longint acc [0:11][0:10];
    longint s, v;
    for (int r = 0; r < 12; r++) for (int c = 0; c < 11; c++) acc[r][c] = 0;
    for (int ch = 0; ch < 10; ch++) begin
      for (int r = 0; r < 14; r++) for (int c = 0; c < 13; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
          s += longint'(img[r+i][c+j]) * longint'(w1[i][j][ch]);
        v = s & 64'hFFFFFF;
        c1m[r][c] = (v >= 64'd8388608) ? 0 : v;
      end
      for (int r = 0; r < 12; r++) for (int c = 0; c < 11; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
          s += c1m[r+i][c+j] * longint'(w2[i][j][ch]);
        v = s & 64'hFFFFFF;
        if (v >= 64'd8388608) v = 0;
        acc[r][c] = (acc[r][c] + v) & 64'hFFFFFF;
      end
    end
    for (int r = 0; r < 12; r++) for (int c = 0; c < 11; c++) exp_buf[r][c] = acc[r][c][23:0];
  endfunction

  // Whenever the result is flagged ready it must equal the model, every cycle.
  always @(negedge clk) begin
    if (!rst && ov && cmp_en) begin
      int bad, br, bc;
      bad = 0; br = 0; bc = 0;
      for (int r = 0; r < 12; r++) for (int c = 0; c < 11; c++)
        if (ob[r][c] !== exp_buf[r][c] && bad == 0) begin bad = 1; br = r; bc = c; end
      checks++;
      if (bad == 0) passes++;
      else $display("FAIL out_buff[%0d][%0d]: got %0d, expected %0d",
                    br, bc, ob[br][bc], exp_buf[br][bc]);
    end
  end

  task automatic set_all(input int pix, input int a, input int b);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 15; c++) img[r][c] = 8'(pix);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int k = 0; k < 10; k++) begin
      w1[i][j][k] = 8'(a);
      w2[i][j][k] = 8'(b);
    end
  endtask

  task automatic rand_all(input int wmax);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 15; c++) img[r][c] = 8'($urandom);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int k = 0; k < 10; k++) begin
      w1[i][j][k] = 8'($urandom_range(2*wmax) - wmax);
      w2[i][j][k] = 8'($urandom_range(2*wmax) - wmax);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    check("valid_low_after_trigger", ov, 0);
    cmp_en = 1'b1;
  endtask

  // Counts edges from the trigger edge until out_valid; optional extra trigger at pulse_at.
  task automatic wait_done(input string name, input int pulse_at);
    int n;
    n = 0;
    while (!ov && n < LAT + 200) begin
      @(posedge clk);
      n++;
      #1;
      trigger = (n == pulse_at - 1);
    end
    trigger = 1'b0;
    check(name, n, LAT);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_cleared(input string name);
    int nz;
    nz = 0;
    for (int r = 0; r < 12; r++) for (int c = 0; c < 11; c++) if (ob[r][c] != 0) nz++;
    check(name, nz, 0);
  endtask

  initial begin
    trigger = 1'b0;
    rst = 1'b1;
    set_all(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", ov, 0);
    check_cleared("reset_buff");
    @(negedge clk);
    rst = 1'b0;

    // all ones: conv1 = 9, conv2 = 81, ten channels -> 810
    cmp_en = 1'b0;
    set_all(1, 1, 1);
    compute_model();
    check("model_ones", exp_buf[5][7], 810);
    start_run();
    wait_done("latency_ones", -10);
    check("dut_ones_corner", ob[11][10], 810);

    // negative conv1 weights kill every map
    cmp_en = 1'b0;
    rand_all(127);
    set_all(0, -1, 0);
    rand_all(127);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int k = 0; k < 10; k++)
      w1[i][j][k] = -8'sd1;
    compute_model();
    check("model_neg_w1", exp_buf[0][0], 0);
    start_run();
    wait_done("latency_neg_w1", -10);
    check("dut_neg_w1", ob[6][6], 0);

    // channel 0 centre taps only -> 2*img[r+2][c+2]
    cmp_en = 1'b0;
    rand_all(0);
    set_all(0, 0, 0);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 15; c++) img[r][c] = 8'($urandom);
    w1[1][1][0] = 8'sd1;
    w2[1][1][0] = 8'sd2;
    compute_model();
    check("model_centre", exp_buf[3][4], 2 * img[5][6]);
    start_run();
    wait_done("latency_centre", -10);
    check("dut_centre", ob[11][10], 2 * img[13][12]);

    // saturation: conv1 = 291465, conv2 wraps with bit 23 set -> 0
    cmp_en = 1'b0;
    set_all(255, 127, 127);
    compute_model();
    check("model_conv1_sat", c1m[0][0], 291465);
    check("model_sat", exp_buf[4][4], 0);
    start_run();
    wait_done("latency_sat", -10);
    check("dut_sat", ob[0][0], 0);

    // mid-run reset aborts, then ones retrigger
    cmp_en = 1'b0;
    rand_all(20);
    compute_model();
    start_run();
    repeat (1000) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", ov, 0);
    check_cleared("abort_buff");
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b0;
    set_all(1, 1, 1);
    compute_model();
    start_run();
    wait_done("latency_after_reset", -10);
    check("dut_after_reset", ob[2][3], 810);

    // ignored busy trigger, then a restart from DONE reproducing the result
    cmp_en = 1'b0;
    rand_all(12);
    compute_model();
    start_run();
    wait_done("latency_busy_trigger", 500);
    start_run();
    check_cleared("restart_clears_buff");
    wait_done("latency_restart", -10);

    // fully random weights
    cmp_en = 1'b0;
    rand_all(127);
    compute_model();
    start_run();
    wait_done("latency_random", -10);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
